// File: rtl/rx_pkg.sv
// Shared types, constants and helpers for the serial frame receiver.
package rx_pkg;

    // Receiver sequencing states, 2-bit encoded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W = 8;

    // Ceiling log2, used to size the data-bit counter.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage : rx_pkg

// File: rtl/shift_reg_en.sv
// Enabled right shift register: new bits enter at the MSB, so the first bit
// shifted in ends up in the LSB after DATA_W shifts.
import rx_pkg::*;

module shift_reg_en #(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rs,
    input  logic              en,
    input  logic              sin,
    output logic [DATA_W-1:0] Po
);

    generate
        if (DATA_W == 1) begin : g_single
            // Single-bit register: a shift is just a load.
            always_ff @(posedge clk or negedge rs) begin
                if (!rs) begin
                    Po <= '0;
                end else if (en) begin
                    Po <= sin;
                end
            end
        end else begin : g_multi
            // Shift one position towards the LSB whenever enabled.
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            always_ff @(posedge clk or negedge rs) begin
                if (!rs) begin
                    Po <= '0;
                end else if (en) begin
                    Po <= {sin, Po[DATA_W-1:1]};
                end
            end
        end
    endgenerate

endmodule : shift_reg_en

// File: rtl/serial_frame_rx_ctrl.sv
// Serial frame receiver controller: start bit detect, DATA_W data shifts,
// stop bit check, and a one-deep valid/ready holding register.
import rx_pkg::*;

module serial_frame_rx_ctrl #(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rs,
    input  logic              sin,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    // A 1-bit frame still needs a 1-bit counter.
    localparam int CNT_W = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] sr;
    logic              shift_en;
    logic              cnt_clear;
    logic              load_word;
    logic              err_set;
    logic              ovr_set;
    logic              slot_free;

    shift_reg_en #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk (clk),
        .rs  (rs),
        .en  (shift_en),
        .sin (sin),
        .Po  (sr)
    );

    assign busy      = (state != IDLE);
    // The holding register can take a word if empty or being drained now.
    assign slot_free = !out_valid || out_ready;

    // State register.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the per-cycle control strobes.
    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        next_state = state;
        shift_en   = 1'b0;
        cnt_clear  = 1'b0;
        load_word  = 1'b0;
        err_set    = 1'b0;
        ovr_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!sin) begin
                    next_state = DATA;
                    cnt_clear  = 1'b1;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                next_state = IDLE;
                if (sin) begin
                    load_word = slot_free;
                    ovr_set   = !slot_free;
                end else begin
                    err_set = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Data-bit counter: cleared on the start bit, advanced once per data bit.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            bit_cnt <= '0;
        end else if (cnt_clear) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Holding register and handshake: a load wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load_word) begin
            out_data  <= sr;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Registered one-cycle status pulses; decoded from exclusive stop cases.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= err_set;
            overrun   <= ovr_set;
        end
    end

endmodule : serial_frame_rx_ctrl

// File: tb/tb_serial_frame_rx_ctrl.sv
// Self-checking bench for serial_frame_rx_ctrl: directed scenarios plus
// randomized frames against a frame-level reference model.
module tb_serial_frame_rx_ctrl;

    localparam int DATA_W = 8;

    localparam int PH_IDLE  = 0;
    localparam int PH_START = 1;
    localparam int PH_DATA  = 2;
    localparam int PH_STOP  = 3;

    logic              clk;
    logic              rs;
    logic              sin;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              frame_err;
    logic              overrun;

    // Reference model state: the holding register and expected pulses.
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ferr;
    logic              m_ovr;
    logic              m_busy;

    int n_cmp;
    int n_err;
    int n_loads;

    serial_frame_rx_ctrl #(
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rs        (rs),
        .sin       (sin),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({ctx, ".out_data"},  32'(out_data),  32'(m_data));
        check({ctx, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
        check({ctx, ".overrun"},   32'(overrun),   32'(m_ovr));
        check({ctx, ".busy"},      32'(busy),      32'(m_busy));
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        m_busy  = 1'b0;
    endtask

    // One bit period: drive at the falling edge, predict, check after rising edge.
    task automatic step(input logic s, input logic r, input int phase,
                        input logic [DATA_W-1:0] word, input string ctx);
        @(negedge clk);
        sin       = s;
        out_ready = r;
        m_ferr    = 1'b0;
        m_ovr     = 1'b0;
        if (phase == PH_STOP && s) begin
            if (!m_valid || r) begin
                m_data  = word;
                m_valid = 1'b1;
                n_loads = n_loads + 1;
            end else begin
                m_ovr = 1'b1;
            end
        end else begin
            if (phase == PH_STOP) m_ferr = 1'b1;
            if (m_valid && r) m_valid = 1'b0;
        end
        m_busy = (phase == PH_START || phase == PH_DATA);
        @(posedge clk);
        #1;
        check_outputs(ctx);
    endtask

    function automatic logic pick_rdy(input int mode);
        if (mode == 2) return logic'($urandom_range(0, 1));
        return logic'(mode);
    endfunction

    // Full frame. rdy_bits / rdy_stop: 0, 1, or 2 for random.
    task automatic send_frame(input logic [DATA_W-1:0] word, input logic stop_bit,
                              input int rdy_bits, input int rdy_stop, input string ctx);
        step(1'b0, pick_rdy(rdy_bits), PH_START, word, ctx);
        for (int i = 0; i < DATA_W; i++) begin
            step(word[i], pick_rdy(rdy_bits), PH_DATA, word, ctx);
        end
        step(stop_bit, pick_rdy(rdy_stop), PH_STOP, word, ctx);
    endtask

    task automatic idle(input int cycles, input int rdy_mode, input string ctx);
        for (int i = 0; i < cycles; i++) begin
            step(1'b1, pick_rdy(rdy_mode), PH_IDLE, '0, ctx);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        n_loads   = 0;
        sin       = 1'b1;
        out_ready = 1'b0;
        rs        = 1'b0;
        model_reset();

        // Reset state, before any clock edge is released.
        #2;
        check_outputs("reset");
        @(negedge clk);
        rs = 1'b1;
        idle(2, 0, "post_reset");

        // Good frame 0xA5, consumer always ready: valid for exactly one cycle.
        send_frame(8'hA5, 1'b1, 1, 1, "good_a5");
        check("good_a5.word", 32'(out_data), 32'h0000_00A5);
        idle(1, 1, "good_a5_drain");
        check("good_a5.cleared", 32'(out_valid), 32'd0);
        idle(2, 1, "gap");

        // Bad stop bit, then a good frame.
        send_frame(8'h3C, 1'b0, 1, 1, "bad_stop");
        check("bad_stop.pulse", 32'(frame_err), 32'd1);
        idle(1, 0, "bad_stop_after");
        check("bad_stop.one_cycle", 32'(frame_err), 32'd0);
        send_frame(8'h81, 1'b1, 0, 0, "after_err");
        check("after_err.word", 32'(out_data), 32'h0000_0081);
        idle(1, 1, "drain");

        // Overrun: holding register full, second word dropped.
        send_frame(8'h11, 1'b1, 0, 0, "ovr_first");
        send_frame(8'h22, 1'b1, 0, 0, "ovr_second");
        check("ovr.pulse", 32'(overrun), 32'd1);
        check("ovr.kept", 32'(out_data), 32'h0000_0011);
        idle(1, 0, "ovr_after");
        idle(1, 1, "ovr_drain");
        check("ovr.drained", 32'(out_valid), 32'd0);

        // Same-cycle consume and load on the stop edge.
        send_frame(8'h11, 1'b1, 0, 0, "same_first");
        send_frame(8'h22, 1'b1, 0, 1, "same_second");
        check("same.no_ovr", 32'(overrun), 32'd0);
        check("same.word", 32'(out_data), 32'h0000_0022);
        check("same.valid", 32'(out_valid), 32'd1);
        idle(1, 1, "same_drain");

        // Back-to-back frames with no idle gap.
        send_frame(8'hFF, 1'b1, 1, 1, "b2b_ff");
        send_frame(8'h00, 1'b1, 1, 1, "b2b_00");
        check("b2b.second", 32'(out_data), 32'h0000_0000);
        send_frame(8'h5A, 1'b1, 1, 1, "b2b_5a");
        check("b2b.third", 32'(out_data), 32'h0000_005A);
        idle(1, 1, "b2b_drain");

        // Reset mid-frame, after four data bits, then a clean frame.
        send_frame(8'h77, 1'b1, 0, 0, "pre_abort");
        step(1'b0, 1'b0, PH_START, '0, "abort_start");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, PH_DATA, '0, "abort_bits");
        end
        @(negedge clk);
        #1;
        rs = 1'b0;
        model_reset();
        #1;
        check_outputs("abort_reset");
        @(negedge clk);
        rs = 1'b1;
        idle(2, 0, "abort_idle");
        send_frame(8'hC3, 1'b1, 0, 0, "after_abort");
        check("after_abort.word", 32'(out_data), 32'h0000_00C3);
        idle(1, 1, "after_abort_drain");

        // Randomized frames: random data, gaps, stop errors and back-pressure.
        for (int f = 0; f < 60; f++) begin
            logic [DATA_W-1:0] word;
            logic              stop_bit;
            word     = DATA_W'($urandom);
            stop_bit = ($urandom_range(0, 4) != 0);
            send_frame(word, stop_bit, 2, 2, "rand");
            idle($urandom_range(0, 2), 2, "rand_gap");
        end
        idle(3, 1, "final_drain");
        check("loads_seen", 32'(n_loads > 20), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute bound so a stuck run still terminates with a report.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "bench timed out");
    end

endmodule : tb_serial_frame_rx_ctrl
